// File: rtl/matrix_operand_feeder.sv
// Buffers serial A/B complex operands, then issues one A row and one B column per cycle for all 16 results.
// Issue outputs registered one cycle after selection; tags trail by EXTRACT_LATENCY; in_ready is low outside LOAD.
module matrix_operand_feeder #(
    parameter int INTEGER_SIZE    = 7,
    parameter int FRACT_SIZE      = 11,
    parameter int DATA_WIDTH      = INTEGER_SIZE + FRACT_SIZE,
    parameter int EXTRACT_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic [DATA_WIDTH-1:0] a1_r,
    output logic [DATA_WIDTH-1:0] a2_r,
    output logic [DATA_WIDTH-1:0] a3_r,
    output logic [DATA_WIDTH-1:0] a4_r,
    output logic [DATA_WIDTH-1:0] a1_i,
    output logic [DATA_WIDTH-1:0] a2_i,
    output logic [DATA_WIDTH-1:0] a3_i,
    output logic [DATA_WIDTH-1:0] a4_i,
    output logic [DATA_WIDTH-1:0] b1_r,
    output logic [DATA_WIDTH-1:0] b2_r,
    output logic [DATA_WIDTH-1:0] b3_r,
    output logic [DATA_WIDTH-1:0] b4_r,
    output logic [DATA_WIDTH-1:0] b1_i,
    output logic [DATA_WIDTH-1:0] b2_i,
    output logic [DATA_WIDTH-1:0] b3_i,
    output logic [DATA_WIDTH-1:0] b4_i,
    output logic                  issue_valid,
    output logic                  res_valid,
    output logic [1:0]            res_row,
    output logic [1:0]            res_col,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [4:0]            r_k;
    logic [3:0]            r_n;
    logic                  r_issue_valid;
    logic [1:0]            r_iss_row;
    logic [1:0]            r_iss_col;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] r_a_r [0:15];
    logic [DATA_WIDTH-1:0] r_a_i [0:15];
    logic [DATA_WIDTH-1:0] r_b_r [0:15];
    logic [DATA_WIDTH-1:0] r_b_i [0:15];

    logic [DATA_WIDTH-1:0] r_oa_r [0:3];
    logic [DATA_WIDTH-1:0] r_oa_i [0:3];
    logic [DATA_WIDTH-1:0] r_ob_r [0:3];
    logic [DATA_WIDTH-1:0] r_ob_i [0:3];

    logic [4:0]            r_tag [0:EXTRACT_LATENCY-1];

    logic                  w_accept;
    logic                  w_tags_pending;

    assign in_ready = (r_state == S_LOAD) && !rst;
    assign w_accept = in_valid && in_ready && !clear;

    // Operand store: word index k maps A for k<16, B for k>=16, raster order.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (!r_k[4]) begin
                r_a_r[r_k[3:0]] <= in_r;
                r_a_i[r_k[3:0]] <= in_i;
            end else begin
                r_b_r[r_k[3:0]] <= in_r;
                r_b_i[r_k[3:0]] <= in_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_LOAD;
            r_k           <= '0;
            r_n           <= '0;
            r_issue_valid <= 1'b0;
            r_iss_row     <= '0;
            r_iss_col     <= '0;
            r_done        <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                r_oa_r[c] <= '0;
                r_oa_i[c] <= '0;
                r_ob_r[c] <= '0;
                r_ob_i[c] <= '0;
            end
        end else if (clear) begin
            r_state       <= S_LOAD;
            r_k           <= '0;
            r_n           <= '0;
            r_issue_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_issue_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_k <= r_k + 5'd1;
                        if (r_k == 5'd31) begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_issue_valid <= 1'b1;
                    r_iss_row     <= r_n[3:2];
                    r_iss_col     <= r_n[1:0];
                    for (int c = 0; c < 4; c++) begin
                        r_oa_r[c] <= r_a_r[{r_n[3:2], 2'(c)}];
                        r_oa_i[c] <= r_a_i[{r_n[3:2], 2'(c)}];
                        r_ob_r[c] <= r_b_r[{2'(c), r_n[1:0]}];
                        r_ob_i[c] <= r_b_i[{2'(c), r_n[1:0]}];
                    end
                    r_n <= r_n + 4'd1;
                    if (r_n == 4'd15) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave once only the final stage can still hold a tag: it is being emitted now.
                    if (!w_tags_pending) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < EXTRACT_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else if (clear) begin
            for (int s = 0; s < EXTRACT_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= {r_issue_valid, r_iss_row, r_iss_col};
            for (int s = 1; s < EXTRACT_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    always_comb begin
        w_tags_pending = r_issue_valid;
        for (int s = 0; s < EXTRACT_LATENCY - 1; s++) begin
            w_tags_pending = w_tags_pending | r_tag[s][4];
        end
    end

    assign a1_r = r_oa_r[0];
    assign a2_r = r_oa_r[1];
    assign a3_r = r_oa_r[2];
    assign a4_r = r_oa_r[3];
    assign a1_i = r_oa_i[0];
    assign a2_i = r_oa_i[1];
    assign a3_i = r_oa_i[2];
    assign a4_i = r_oa_i[3];
    assign b1_r = r_ob_r[0];
    assign b2_r = r_ob_r[1];
    assign b3_r = r_ob_r[2];
    assign b4_r = r_ob_r[3];
    assign b1_i = r_ob_i[0];
    assign b2_i = r_ob_i[1];
    assign b3_i = r_ob_i[2];
    assign b4_i = r_ob_i[3];

    assign issue_valid = r_issue_valid;
    assign res_valid   = r_tag[EXTRACT_LATENCY-1][4];
    assign res_row     = r_tag[EXTRACT_LATENCY-1][3:2];
    assign res_col     = r_tag[EXTRACT_LATENCY-1][1:0];
    assign busy        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done        = r_done;

endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Directed bench for matrix_operand_feeder: load/issue/tag timing, gaps, clear, async reset, signed extremes.
module tb_matrix_operand_feeder;

    localparam int DW   = 18;
    localparam int LAT  = 3;
    localparam int NCAP = 28;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_r = '0;
    logic [DW-1:0] in_i = '0;
    logic          in_ready;
    logic [DW-1:0] a1_r, a2_r, a3_r, a4_r, a1_i, a2_i, a3_i, a4_i;
    logic [DW-1:0] b1_r, b2_r, b3_r, b4_r, b1_i, b2_i, b3_i, b4_i;
    logic          issue_valid, res_valid, busy, done;
    logic [1:0]    res_row, res_col;

    matrix_operand_feeder #(
        .INTEGER_SIZE(7), .FRACT_SIZE(11), .DATA_WIDTH(DW), .EXTRACT_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i),
        .a1_r(a1_r), .a2_r(a2_r), .a3_r(a3_r), .a4_r(a4_r),
        .a1_i(a1_i), .a2_i(a2_i), .a3_i(a3_i), .a4_i(a4_i),
        .b1_r(b1_r), .b2_r(b2_r), .b3_r(b3_r), .b4_r(b4_r),
        .b1_i(b1_i), .b2_i(b2_i), .b3_i(b3_i), .b4_i(b4_i),
        .issue_valid(issue_valid), .res_valid(res_valid),
        .res_row(res_row), .res_col(res_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    wire [287:0] w_bus = {a1_r, a2_r, a3_r, a4_r, a1_i, a2_i, a3_i, a4_i,
                          b1_r, b2_r, b3_r, b4_r, b1_i, b2_i, b3_i, b4_i};
    wire [8:0]   w_stat = {in_ready, issue_valid, res_valid, res_row, res_col, busy, done};

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ma_r [0:15];
    logic [DW-1:0] ma_i [0:15];
    logic [DW-1:0] mb_r [0:15];
    logic [DW-1:0] mb_i [0:15];
    logic [DW-1:0] ext  [0:2];

    logic          cap_iv   [0:NCAP-1];
    logic          cap_rv   [0:NCAP-1];
    logic          cap_done [0:NCAP-1];
    logic          cap_rdy  [0:NCAP-1];
    logic          cap_busy [0:NCAP-1];
    logic [3:0]    cap_rc   [0:NCAP-1];
    logic [287:0]  cap_bus  [0:NCAP-1];

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [287:0] exp_bus(input int n);
        int i;
        int j;
        i = n / 4;
        j = n % 4;
        return {ma_r[i*4+0], ma_r[i*4+1], ma_r[i*4+2], ma_r[i*4+3],
                ma_i[i*4+0], ma_i[i*4+1], ma_i[i*4+2], ma_i[i*4+3],
                mb_r[0+j], mb_r[4+j], mb_r[8+j], mb_r[12+j],
                mb_i[0+j], mb_i[4+j], mb_i[8+j], mb_i[12+j]};
    endfunction

    task automatic random_model();
        for (int e = 0; e < 16; e++) begin
            ma_r[e] = DW'($urandom);
            ma_i[e] = DW'($urandom);
            mb_r[e] = DW'($urandom);
            mb_i[e] = DW'($urandom);
        end
    endtask

    // Presents the 32 words; returns at the negedge where the DUT has entered ISSUE.
    task automatic load_all(input bit gaps);
        int rdy_low;
        rdy_low = 0;
        for (int w = 0; w < 32; w++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_r = DW'($urandom);
                    in_i = DW'($urandom);
                    if (!in_ready) rdy_low++;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_r = (w < 16) ? ma_r[w] : mb_r[w-16];
            in_i = (w < 16) ? ma_i[w] : mb_i[w-16];
            if (!in_ready) rdy_low++;
            if (gaps && w == 31) begin
                check("gaps_busy_before_last", {287'd0, busy}, 288'd0);
                check("gaps_rdy_low_count", rdy_low, 0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Records outputs per cycle while holding in_valid high with junk until DONE.
    task automatic capture();
        for (int t = 0; t < NCAP; t++) begin
            cap_iv[t]   = issue_valid;
            cap_rv[t]   = res_valid;
            cap_done[t] = done;
            cap_rdy[t]  = in_ready;
            cap_busy[t] = busy;
            cap_rc[t]   = {res_row, res_col};
            cap_bus[t]  = w_bus;
            in_valid = (t < 16 + LAT);
            in_r = DW'($urandom);
            in_i = DW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic verify(input string tag);
        int iv_cnt, first_iv, last_iv, rv_cnt, first_rv, last_rv;
        int done_cnt, done_t, rdy_hi, data_bad, seq_bad;
        iv_cnt = 0; first_iv = -1; last_iv = -1; rv_cnt = 0; first_rv = -1; last_rv = -1;
        done_cnt = 0; done_t = -1; rdy_hi = 0; data_bad = 0; seq_bad = 0;
        for (int t = 0; t < NCAP; t++) begin
            if (cap_iv[t]) begin
                if (first_iv < 0) first_iv = t;
                last_iv = t;
                if (cap_bus[t] !== exp_bus(iv_cnt)) data_bad++;
                iv_cnt++;
            end
            if (cap_rv[t]) begin
                if (first_rv < 0) first_rv = t;
                last_rv = t;
                if (cap_rc[t] !== rv_cnt[3:0]) seq_bad++;
                rv_cnt++;
            end
            if (cap_done[t]) begin
                done_cnt++;
                done_t = t;
            end
            if (done_cnt == 0 && cap_rdy[t]) rdy_hi++;
        end
        check({tag, "_issue_count"}, iv_cnt, 16);
        check({tag, "_first_issue"}, first_iv, 1);
        check({tag, "_issue_span"}, last_iv - first_iv, 15);
        check({tag, "_issue_data"}, data_bad, 0);
        check({tag, "_res_count"}, rv_cnt, 16);
        check({tag, "_res_latency"}, first_rv - first_iv, LAT);
        check({tag, "_res_rowcol"}, seq_bad, 0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_after_last"}, done_t - last_rv, 1);
        check({tag, "_rdy_low_busy"}, rdy_hi, 0);
        check({tag, "_busy_first"}, {287'd0, cap_busy[0]}, 288'd1);
        check({tag, "_rdy_after_done"}, {287'd0, (done_t >= 0 && done_t < NCAP - 1) ? cap_rdy[done_t+1] : 1'b0}, 288'd1);
    endtask

    initial begin
        int iv_seen, rv_seen, done_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_status", w_stat, 288'd0);
        check("rst_bus", w_bus, 288'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {287'd0, in_ready}, 288'd1);
        @(negedge clk);

        // Identity A, B[r][c] = (4r+c) - j r in Q7.11
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma_r[r*4+c] = (r == c) ? 18'h00800 : 18'h0;
                ma_i[r*4+c] = 18'h0;
                mb_r[r*4+c] = DW'((r*4 + c) * 2048);
                mb_i[r*4+c] = DW'(-r * 2048);
            end
        end
        load_all(1'b0);
        capture();
        verify("ident");
        check("ident_n5_hand", cap_bus[6],
              {18'h0, 18'h00800, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0,
               18'h00800, 18'h02800, 18'h04800, 18'h06800,
               18'h0, 18'h3F800, 18'h3F000, 18'h3E800});

        // Gapped load
        random_model();
        load_all(1'b1);
        capture();
        verify("gaps");

        // Clear while issuing n=7
        random_model();
        load_all(1'b0);
        repeat (8) @(negedge clk);
        check("clr_pre_issue", {issue_valid, w_bus}, {1'b1, exp_bus(7)});
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_next", {285'd0, issue_valid, in_ready, busy}, {285'd0, 3'b010});
        iv_seen = 0; rv_seen = 0; done_seen = 0;
        for (int t = 0; t < 25; t++) begin
            if (issue_valid) iv_seen++;
            if (res_valid) rv_seen++;
            if (done) done_seen++;
            @(negedge clk);
        end
        check("clr_quiet", {iv_seen, rv_seen, done_seen}, 96'd0);
        // Word presented together with clear must be dropped
        in_valid = 1'b1;
        in_r = 18'h15555;
        in_i = 18'h2AAAA;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        random_model();
        load_all(1'b0);
        capture();
        verify("after_clear");

        // Async reset in DRAIN
        random_model();
        load_all(1'b0);
        repeat (17) @(negedge clk);
        check("drain_busy", {287'd0, busy}, 288'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_status", w_stat, 288'd0);
        check("async_rst_bus", w_bus, 288'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_rst_ready", {287'd0, in_ready}, 288'd1);
        random_model();
        load_all(1'b0);
        capture();
        verify("after_rst");

        // Signed extremes
        ext[0] = 18'h1FFFF;
        ext[1] = 18'h20000;
        ext[2] = 18'h3FFFF;
        for (int e = 0; e < 16; e++) begin
            ma_r[e] = ext[e % 3];
            ma_i[e] = ext[(e + 1) % 3];
            mb_r[e] = ext[(e + 2) % 3];
            mb_i[e] = ext[(e * 2) % 3];
        end
        load_all(1'b0);
        capture();
        verify("extreme");
        check("extreme_a_row0_hand", cap_bus[1][287:216], {18'h1FFFF, 18'h20000, 18'h3FFFF, 18'h1FFFF});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
